// File: rtl/step_sequencer.sv
// Tempo-driven step sequencer that produces the note index for the note mux.
// It supports play/pause, restart, looping and an end-of-step mute gap.
module step_sequencer #(
  parameter int unsigned TICKS_PER_STEP = 12_500_000,
  parameter int unsigned GAP_TICKS      = 625_000,
  parameter int unsigned LAST_STEP      = 194
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play,
  input  logic       restart,
  input  logic       loop,
  output logic [7:0] sel,
  output logic       mute,
  output logic       step_strobe,
  output logic       done
);

  localparam int unsigned         TICK_W    = $clog2(TICKS_PER_STEP);
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
  localparam int unsigned         MUTE_FROM = TICKS_PER_STEP - GAP_TICKS;
  localparam logic [7:0]          SEL_LAST  = 8'(LAST_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [7:0]        sel_q, sel_d;
  logic              step_strobe_q, step_strobe_d;
  logic              done_q, done_d;

  always_comb begin
    state_d       = state_q;
    tick_d        = tick_q;
    sel_d         = sel_q;
    step_strobe_d = 1'b0;

    if (restart) begin
      sel_d   = 8'd0;
      tick_d  = '0;
      state_d = play ? PLAY : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (play) begin
            state_d = PLAY;
            tick_d  = '0;
            sel_d   = 8'd0;
          end
        end
        PLAY: begin
          // Pausing wins over a step boundary on the same edge; tick stays put.
          if (!play) begin
            state_d = PAUSE;
          end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (sel_q < SEL_LAST) begin
              sel_d         = sel_q + 8'd1;
              step_strobe_d = 1'b1;
            end else if (loop) begin
              sel_d         = 8'd0;
              step_strobe_d = 1'b1;
            end else begin
              state_d = DONE;
              sel_d   = SEL_LAST;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        PAUSE: begin
          if (play) begin
            state_d = PLAY;
          end
        end
        DONE: begin
          sel_d = SEL_LAST;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tick_q        <= '0;
      sel_q         <= 8'd0;
      step_strobe_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      sel_q         <= sel_d;
      step_strobe_q <= step_strobe_d;
      done_q        <= done_d;
    end
  end

  // Mute is decoded straight from the registers so it changes with sel.
  assign mute        = (state_q != PLAY) || (32'(tick_q) >= MUTE_FROM);
  assign sel         = sel_q;
  assign step_strobe = step_strobe_q;
  assign done        = done_q;

endmodule
